// File: rtl/mem_pkg.sv
// Shared encodings for the load unit: access sizes, error codes and controller states.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // Halfwords must sit on even bytes, words on 4-byte boundaries.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mdr_extract.sv
// Combinational lane select and zero/sign extension of the latched memory word.
module mdr_extract
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        result   = word;
        case (offset)
            2'b00:   byte_sel = word[7:0];
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Multi-cycle load controller: validates the request, reads one word over a req/ack bus,
// latches it into the MDR and presents the extracted, extended result.
module mem_load_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] mdr_out,
    output logic [31:0] data_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_req_q, mem_req_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [1:0]  lat_off_q, lat_off_d;
    logic [1:0]  lat_size_q, lat_size_d;
    logic        lat_sign_q, lat_sign_d;
    // Extraction controls are copied on ack so data_out only moves together with the MDR.
    logic [1:0]  ext_off_q, ext_off_d;
    logic [1:0]  ext_size_q, ext_size_d;
    logic        ext_sign_q, ext_sign_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        mdr_d      = mdr_q;
        mem_addr_d = mem_addr_q;
        lat_off_d  = lat_off_q;
        lat_size_d = lat_size_q;
        lat_sign_d = lat_sign_q;
        ext_off_d  = ext_off_q;
        ext_size_d = ext_size_q;
        ext_sign_d = ext_sign_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lat_off_d  = addr[1:0];
                    lat_size_d = size;
                    lat_sign_d = sign_ext;
                    mem_addr_d = {addr[31:2], 2'b00};
                    cnt_d      = 8'd0;
                    if (size == SZ_ILL) begin
                        err_code_d = ERR_SIZE;
                        state_d    = ST_ERR;
                    end else if (is_misaligned(size, addr[1:0])) begin
                        err_code_d = ERR_MISALIGN;
                        state_d    = ST_ERR;
                    end else begin
                        err_code_d = ERR_NONE;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    mdr_d      = mem_rdata;
                    ext_off_d  = lat_off_q;
                    ext_size_d = lat_size_q;
                    ext_sign_d = lat_sign_q;
                    state_d    = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d    = (state_d != ST_IDLE);
        mem_req_d = (state_d == ST_REQ);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            mdr_q      <= 32'd0;
            mem_addr_q <= 32'd0;
            lat_off_q  <= 2'b00;
            lat_size_q <= 2'b00;
            lat_sign_q <= 1'b0;
            ext_off_q  <= 2'b00;
            ext_size_q <= 2'b00;
            ext_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
            err_code_q <= err_code_d;
            mdr_q      <= mdr_d;
            mem_addr_q <= mem_addr_d;
            lat_off_q  <= lat_off_d;
            lat_size_q <= lat_size_d;
            lat_sign_q <= lat_sign_d;
            ext_off_q  <= ext_off_d;
            ext_size_q <= ext_size_d;
            ext_sign_q <= ext_sign_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign mdr_out  = mdr_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    mdr_extract u_extract (
        .word     (mdr_q),
        .offset   (ext_off_q),
        .size     (ext_size_q),
        .sign_ext (ext_sign_q),
        .result   (data_out)
    );

endmodule

// File: tb/tb_mem_load_unit.sv
// Scenario bench for mem_load_unit with TIMEOUT=4; expected load results flow through a queue.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        rst, start, sign_ext;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        busy, done, err, mem_req, mem_ack;
    logic [1:0]  err_code;
    logic [31:0] mdr_out, data_out, mem_addr, mem_rdata;
    logic        ack_tie, ack_drv;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_mdr_q[$];
    logic [31:0] last_mdr;

    always #5 clk = ~clk;

    assign mem_ack = ack_tie ? mem_req : ack_drv;

    mem_load_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .size(size), .sign_ext(sign_ext),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .mdr_out(mdr_out),
        .data_out(data_out), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic s);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (sz)
            2'b00:   return (s && sh[7]) ? (32'hFFFF_FF00 | {24'h0, sh[7:0]}) : {24'h0, sh[7:0]};
            2'b01:   return (s && sh[15]) ? (32'hFFFF_0000 | {16'h0, sh[15:0]}) : {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Issues one load in the current cycle; ack arrives after 'waits' idle REQ cycles.
    task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic s,
                            input logic [31:0] rd, input int waits, input logic tie,
                            input logic [31:0] exp_data, input string name);
        int done_cyc;
        logic [31:0] e;
        done_cyc = -1;
        exp_q.push_back(exp_data);
        exp_mdr_q.push_back(rd);
        ack_tie = tie; mem_rdata = rd;
        start = 1'b1; addr = a; size = sz; sign_ext = s;
        tick;
        start = 1'b0; addr = $urandom; size = 2'(~sz); sign_ext = ~s;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL %s mem_req_c1: got %b want 1", name, mem_req);
        end
        checks++;
        if (mem_addr !== {a[31:2], 2'b00}) begin
            errors++; $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, {a[31:2], 2'b00});
        end
        checks++;
        if (err_code !== 2'b00) begin
            errors++; $display("FAIL %s err_code_clr: got %b want 00", name, err_code);
        end
        for (int c = 1; c <= 12; c++) begin
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            ack_drv = (!tie && (c == waits + 1));
            tick;
        end
        ack_drv = 1'b0; ack_tie = 1'b0;
        checks++;
        if (done_cyc != waits + 2) begin
            errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, waits + 2);
        end
        e = exp_q.pop_front();
        last_mdr = exp_mdr_q.pop_front();
        if (done_cyc >= 0) begin
            checks++;
            if (data_out !== e) begin
                errors++; $display("FAIL %s data_out: got %h want %h", name, data_out, e);
            end
            checks++;
            if (mdr_out !== last_mdr) begin
                errors++; $display("FAIL %s mdr_out: got %h want %h", name, mdr_out, last_mdr);
            end
            checks++;
            if (mem_req !== 1'b0) begin
                errors++; $display("FAIL %s mem_req_done: got %b want 0", name, mem_req);
            end
        end
        tick;
        checks++;
        if ({busy, done} !== 2'b00 || data_out !== e) begin
            errors++; $display("FAIL %s idle_hold: busy=%b done=%b data=%h want 0 0 %h",
                               name, busy, done, data_out, e);
        end
    endtask

    task automatic run_err(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] code,
                           input string name);
        logic [31:0] d_before;
        d_before = data_out;
        start = 1'b1; addr = a; size = sz; sign_ext = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({err, mem_req, busy} !== 3'b101 || err_code !== code) begin
            errors++; $display("FAIL %s err_c1: err=%b req=%b busy=%b code=%b want 1 0 1 %b",
                               name, err, mem_req, busy, err_code, code);
        end
        checks++;
        if (mdr_out !== last_mdr || data_out !== d_before) begin
            errors++; $display("FAIL %s mdr_hold: mdr=%h data=%h want %h %h",
                               name, mdr_out, data_out, last_mdr, d_before);
        end
        tick;
        checks++;
        if ({err, mem_req, busy} !== 3'b000 || err_code !== code) begin
            errors++; $display("FAIL %s err_c2: err=%b req=%b busy=%b code=%b want 0 0 0 %b",
                               name, err, mem_req, busy, err_code, code);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; addr = 32'h0; size = 2'b00; sign_ext = 1'b0;
        ack_tie = 1'b0; ack_drv = 1'b0; mem_rdata = 32'h0;
        tick; tick;
        checks++;
        if ({busy, done, err, mem_req, err_code} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, err, mem_req, err_code});
        end
        checks++;
        if (mdr_out !== 32'h0 || data_out !== 32'h0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_data: mdr=%h data=%h addr=%h want 0", mdr_out, data_out, mem_addr);
        end
        rst = 1'b0; last_mdr = 32'h0;
        tick;
    endtask

    task automatic test_word_zero_wait;
        run_load(32'h100, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 1'b1, 32'hDEAD_BEEF, "word_zw");
    endtask

    task automatic test_half;
        run_load(32'h102, 2'b01, 1'b1, 32'h8001_1234, 3, 1'b0, 32'hFFFF_8001, "half_s");
        run_load(32'h102, 2'b01, 1'b0, 32'h8001_1234, 3, 1'b0, 32'h0000_8001, "half_z");
    endtask

    task automatic test_byte;
        run_load(32'h203, 2'b00, 1'b1, 32'h7F00_0000, 1, 1'b0, 32'h0000_007F, "byte_l3");
        run_load(32'h201, 2'b00, 1'b1, 32'h0000_8000, 0, 1'b0, 32'hFFFF_FF80, "byte_l1");
    endtask

    task automatic test_errors;
        run_err(32'h101, 2'b01, 2'b01, "mis_half");
        run_err(32'h102, 2'b10, 2'b01, "mis_word");
        run_err(32'h100, 2'b11, 2'b11, "ill_size");
    endtask

    task automatic test_timeout;
        logic [31:0] d_before;
        d_before = data_out;
        start = 1'b1; addr = 32'h300; size = 2'b10; sign_ext = 1'b0;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (mem_req !== 1'b1 || err !== 1'b0) begin
                errors++; $display("FAIL timeout_req c%0d: req=%b err=%b want 1 0", c, mem_req, err);
            end
            tick;
        end
        checks++;
        if ({err, mem_req} !== 2'b10 || err_code !== 2'b10) begin
            errors++; $display("FAIL timeout_err: err=%b req=%b code=%b want 1 0 10", err, mem_req, err_code);
        end
        checks++;
        if (mdr_out !== last_mdr || data_out !== d_before) begin
            errors++; $display("FAIL timeout_hold: mdr=%h data=%h want %h %h", mdr_out, data_out, last_mdr, d_before);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        start = 1'b1; addr = 32'h400; size = 2'b10; sign_ext = 1'b0;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({busy, done, err, mem_req, err_code} !== 6'b0 || mdr_out !== 32'h0 ||
            data_out !== 32'h0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mid: ctrl=%b mdr=%h data=%h addr=%h want all 0",
                               {busy, done, err, mem_req, err_code}, mdr_out, data_out, mem_addr);
        end
        last_mdr = 32'h0;
        ack_drv = 1'b1; mem_rdata = 32'h1234_5678;
        tick; tick;
        checks++;
        if (mdr_out !== 32'h0 || done !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL late_ack: mdr=%h done=%b req=%b want 0 0 0", mdr_out, done, mem_req);
        end
        ack_drv = 1'b0;
        tick;
    endtask

    task automatic test_start_while_busy;
        exp_q.push_back(32'hCAFE_F00D);
        mem_rdata = 32'hCAFE_F00D;
        start = 1'b1; addr = 32'h500; size = 2'b10; sign_ext = 1'b0;
        tick;
        addr = 32'h601; size = 2'b00; sign_ext = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (mem_addr !== 32'h500 || mem_req !== 1'b1) begin
            errors++; $display("FAIL busy_start_addr: addr=%h req=%b want 500 1", mem_addr, mem_req);
        end
        ack_drv = 1'b1;
        tick;
        ack_drv = 1'b0;
        checks++;
        if (done !== 1'b1 || data_out !== exp_q[0]) begin
            errors++; $display("FAIL busy_start_done: done=%b data=%h want 1 %h", done, data_out, exp_q[0]);
        end
        void'(exp_q.pop_front());
        last_mdr = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++;
            if (mem_req !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL busy_start_extra c%0d: req=%b busy=%b want 0 0", c, mem_req, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  sz, off;
            logic [31:0] rd, a;
            logic        s;
            sz  = 2'($urandom_range(0, 2));
            off = (sz == 2'b00) ? 2'($urandom_range(0, 3)) : (sz == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            a   = ($urandom & 32'hFFFF_FFFC) | {30'h0, off};
            rd  = $urandom;
            s   = 1'($urandom_range(0, 1));
            run_load(a, sz, s, rd, $urandom_range(0, 3), 1'b0, model(rd, off, sz, s), "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_word_zero_wait();
        test_half();
        test_byte();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
